vga_pixel_out: RTL and testbench

VGA_PIXEL_OUT -- requirements
Module: vga_pixel_out

---
 rtl/vga_pkg.sv | 46 ++++
 rtl/vga_sync_dly.sv | 40 ++++
 rtl/vga_pixel_out.sv | 142 ++++++++++++++
 tb/tb_vga_pixel_out.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// ---------------------------------------------------------------------------
// vga_pkg
// Shared constants and helpers for the VGA output path.
//   RGB_W          : width of the 3-bit DAC colour bus
//   BLACK..BLUE    : named colour codes {r,g,b}
//   H_* / V_*      : 640x480 @ 60 Hz timing, in pixels and lines
//   blink_phase_e  : state of the optional text blink
//   pixel_gate()   : final blanking / hiding mux for one pixel
// ---------------------------------------------------------------------------
package vga_pkg;

  localparam int RGB_W = 3;

  localparam logic [RGB_W-1:0] BLACK = 3'b000;
  localparam logic [RGB_W-1:0] RED   = 3'b100;
  localparam logic [RGB_W-1:0] GREEN = 3'b010;
  localparam logic [RGB_W-1:0] BLUE  = 3'b001;

  localparam int H_DISPLAY = 640;
  localparam int H_FRONT   = 16;
  localparam int H_SYNC    = 96;
  localparam int H_BACK    = 48;
  localparam int H_TOTAL   = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;

  localparam int V_DISPLAY = 480;
  localparam int V_FRONT   = 10;
  localparam int V_SYNC    = 2;
  localparam int V_BACK    = 33;
  localparam int V_TOTAL   = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  typedef enum logic {
    BLINK_VISIBLE = 1'b0,
    BLINK_HIDDEN  = 1'b1
  } blink_phase_e;

  // Outside the visible area, or while text is being hidden, the DAC
  // must see black; otherwise the text colour passes straight through.
  function automatic logic [RGB_W-1:0] pixel_gate(
    input logic             video_on,
    input logic             hide,
    input logic [RGB_W-1:0] colour
  );
    return (!video_on || hide) ? BLACK : colour;
  endfunction

endpackage

// File: rtl/vga_sync_dly.sv
// ---------------------------------------------------------------------------
// vga_sync_dly
// Enable-qualified shift register that delays a small bundle of sync flags
// by DEPTH stages. Stages only move when en_i is high.
//   clk    : system clock
//   reset  : synchronous, active-low clear of every stage
//   en_i   : stage advance enable (pixel tick)
//   din_i  : flags entering the line
//   dout_o : flags leaving the last stage (a register output)
// ---------------------------------------------------------------------------
module vga_sync_dly #(
  parameter int WIDTH = 3,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o
);

  logic [WIDTH-1:0] stage_q [DEPTH];

  // Shift one position per enabled clock; stage 0 takes the new input.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= '0;
      end
    end else if (en_i) begin
      stage_q[0] <= din_i;
      for (int i = 1; i < DEPTH; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign dout_o = stage_q[DEPTH-1];

endmodule

// File: rtl/vga_pixel_out.sv
// ---------------------------------------------------------------------------
// vga_pixel_out
// Final stage of the VGA path: re-times the sync generator flags, lines the
// text colour up with them, blanks outside the visible area and counts
// frames. Optional text blink is compiled in with macro VGA_TEXT_BLINK_EN.
//   clk, reset   : system clock, synchronous active-low reset
//   p_tick       : pixel enable; all pipeline state advances only on it
//   hsync_in, vsync_in, video_on_in : flags from the sync generator
//   text_on      : {k,i,r} region flags from the text generator
//   text_rgb     : text colour, SYNC_DLY-1 ticks behind the sync flags
//   hsync, vsync : delayed syncs to the connector
//   rgb          : pixel colour to the DAC
//   frame_cnt    : number of vsync rising edges seen (wraps at 16 bits)
// ---------------------------------------------------------------------------
module vga_pixel_out
  import vga_pkg::*;
#(
  parameter int SYNC_DLY     = 2,
  parameter int BLINK_FRAMES = 30
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             p_tick,
  input  logic             hsync_in,
  input  logic             vsync_in,
  input  logic             video_on_in,
  input  logic [2:0]       text_on,
  input  logic [RGB_W-1:0] text_rgb,
  output logic             hsync,
  output logic             vsync,
  output logic [RGB_W-1:0] rgb,
  output logic [15:0]      frame_cnt
);

  if (SYNC_DLY < 1 || SYNC_DLY > 4) begin : g_bad_sync_dly
    $error("vga_pixel_out: SYNC_DLY must be 1..4");
  end
  if (BLINK_FRAMES < 1 || BLINK_FRAMES > 255) begin : g_bad_blink_frames
    $error("vga_pixel_out: BLINK_FRAMES must be 1..255");
  end

  // The delay line starts out full of cleared zeros. An edge is only
  // trusted once both the current and previous delayed vsync samples come
  // from real input, i.e. after SYNC_DLY+1 ticks; otherwise a vsync that
  // was already high across reset would look like a fresh rising edge.
  localparam logic [2:0] FILL_FULL = 3'(SYNC_DLY + 1);

  logic [2:0]       sync_dly;
  logic             vsync_dly;
  logic             video_on_dly;

  logic [RGB_W-1:0] text_rgb_q;
  logic [2:0]       text_on_q;
  logic             vs_prev_q;
  logic [2:0]       fill_q, fill_d;
  logic [15:0]      frame_cnt_q, frame_cnt_d;
  logic             vs_edge;
  logic             hide;

  vga_sync_dly #(
    .WIDTH (3),
    .DEPTH (SYNC_DLY)
  ) u_sync_dly (
    .clk    (clk),
    .reset  (reset),
    .en_i   (p_tick),
    .din_i  ({hsync_in, vsync_in, video_on_in}),
    .dout_o (sync_dly)
  );

  assign vsync_dly    = sync_dly[1];
  assign video_on_dly = sync_dly[0];

  // Rising-edge detect on the delayed vsync plus next-state for the
  // frame counter and the post-reset fill counter.
  always_comb begin
    vs_edge     = p_tick && (fill_q == FILL_FULL) && vsync_dly && !vs_prev_q;
    frame_cnt_d = frame_cnt_q + {15'd0, vs_edge};
    fill_d      = fill_q;
    if (p_tick && (fill_q != FILL_FULL)) begin
      fill_d = fill_q + 3'd1;
    end
  end

  // Text stage and edge-detect history; one stage on text_rgb/text_on is
  // what lines them up with the SYNC_DLY-deep sync flags.
  always_ff @(posedge clk) begin
    if (!reset) begin
      text_rgb_q  <= BLACK;
      text_on_q   <= '0;
      vs_prev_q   <= 1'b0;
      fill_q      <= '0;
      frame_cnt_q <= '0;
    end else begin
      if (p_tick) begin
        text_rgb_q <= text_rgb;
        text_on_q  <= text_on;
        vs_prev_q  <= vsync_dly;
      end
      fill_q      <= fill_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

`ifdef VGA_TEXT_BLINK_EN
  localparam logic [7:0] BLINK_LAST = 8'(BLINK_FRAMES - 1);

  logic [7:0]   blink_cnt_q;
  blink_phase_e blink_q;

  // Blink phase machine: count frames and flip visibility every
  // BLINK_FRAMES frames.
  always_ff @(posedge clk) begin
    if (!reset) begin
      blink_cnt_q <= '0;
      blink_q     <= BLINK_VISIBLE;
    end else if (vs_edge) begin
      if (blink_cnt_q == BLINK_LAST) begin
        blink_cnt_q <= '0;
        blink_q     <= (blink_q == BLINK_VISIBLE) ? BLINK_HIDDEN : BLINK_VISIBLE;
      end else begin
        blink_cnt_q <= blink_cnt_q + 8'd1;
      end
    end
  end

  assign hide = (blink_q == BLINK_HIDDEN) && (text_on_q != 3'b000);
`else
  // Without blink, text is always shown and the region flags have no job.
  logic text_on_unused;
  assign text_on_unused = |text_on_q;
  assign hide           = 1'b0;
`endif

  // Every term here is a flop output, so hsync, vsync and rgb all change
  // on the same clock edge.
  assign hsync     = sync_dly[2];
  assign vsync     = vsync_dly;
  assign rgb       = pixel_gate(video_on_dly, hide, text_rgb_q);
  assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_vga_pixel_out.sv
// ---------------------------------------------------------------------------
// tb_vga_pixel_out
// Directed sequence with randomised text/sync noise, checked every clock
// against a history-based reference model of the pixel output stage.
// ---------------------------------------------------------------------------
module tb_vga_pixel_out;
  import vga_pkg::*;

  localparam int TB_SYNC_DLY = 2;
  localparam int TB_BLINK    = 2;

  // Shortened frame geometry so many whole frames fit in a short run.
  localparam int SH_TOT = 20;
  localparam int SH_VIS = 12;
  localparam int SH_S0  = 14;
  localparam int SH_S1  = 16;
  localparam int SV_TOT = 8;
  localparam int SV_VIS = 6;
  localparam int SV_SL  = 7;

  logic        clk;
  logic        rstN;
  logic        pTick;
  logic        hsIn, vsIn, voIn;
  logic [2:0]  textOn;
  logic [2:0]  textRgb;
  logic        hsync, vsync;
  logic [2:0]  rgb;
  logic [15:0] frameCnt;

  int checkCount = 0;
  int passCount  = 0;
  int failCount  = 0;

  typedef struct packed {
    logic       hs;
    logic       vs;
    logic       vo;
    logic [2:0] trgb;
    logic [2:0] ton;
  } samp_t;

  // Reference model state: every input sample accepted on a pixel tick
  // since the last reset, the number of vsync rising edges that have made
  // it through the delay, and an offset for a preloaded frame count.
  samp_t       hist[$];
  int          edges = 0;
  logic [15:0] frameBase = '0;

  vga_pixel_out #(
    .SYNC_DLY     (TB_SYNC_DLY),
    .BLINK_FRAMES (TB_BLINK)
  ) dut (
    .clk         (clk),
    .reset       (rstN),
    .p_tick      (pTick),
    .hsync_in    (hsIn),
    .vsync_in    (vsIn),
    .video_on_in (voIn),
    .text_on     (textOn),
    .text_rgb    (textRgb),
    .hsync       (hsync),
    .vsync       (vsync),
    .rgb         (rgb),
    .frame_cnt   (frameCnt)
  );

  // 10 ns system clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One comparison: count it, pass or report.
  task automatic checkVal(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checkCount++;
    assert (got === exp) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive one clock worth of inputs on the falling edge, advance the model
  // on the rising edge, then settle 1 ns before anyone samples outputs.
  task automatic applyStimulus(input logic rn, input logic pt, input logic hs, input logic vs,
                               input logic vo, input logic [2:0] trgb, input logic [2:0] ton);
    samp_t s;
    int k, c;
    @(negedge clk);
    rstN = rn; pTick = pt; hsIn = hs; vsIn = vs; voIn = vo; textRgb = trgb; textOn = ton;
    @(posedge clk);
    if (!rn) begin
      hist.delete();
      edges     = 0;
      frameBase = '0;
    end else if (pt) begin
      s.hs = hs; s.vs = vs; s.vo = vo; s.trgb = trgb; s.ton = ton;
      hist.push_back(s);
      k = hist.size();
      c = k - TB_SYNC_DLY - 1;
      if (c >= 1 && !hist[c-1].vs && hist[c].vs) edges++;
    end
    #1;
  endtask

  // Compare all outputs with what the model predicts after the samples so far.
  task automatic checkOutput(input string tag);
    int         k;
    logic       eHs, eVs, eVo, hidden;
    logic [2:0] tRgb, tOn, eRgb;
    k    = hist.size();
    eHs  = (k >= TB_SYNC_DLY) ? hist[k-TB_SYNC_DLY].hs : 1'b0;
    eVs  = (k >= TB_SYNC_DLY) ? hist[k-TB_SYNC_DLY].vs : 1'b0;
    eVo  = (k >= TB_SYNC_DLY) ? hist[k-TB_SYNC_DLY].vo : 1'b0;
    tRgb = (k >= 1) ? hist[k-1].trgb : 3'b000;
    tOn  = (k >= 1) ? hist[k-1].ton  : 3'b000;
    hidden = 1'b0;
`ifdef VGA_TEXT_BLINK_EN
    hidden = ((edges / TB_BLINK) % 2) == 1;
`endif
    eRgb = (!eVo || (hidden && tOn != 3'b000)) ? BLACK : tRgb;
    checkVal($sformatf("%s.hsync", tag), {15'd0, hsync}, {15'd0, eHs});
    checkVal($sformatf("%s.vsync", tag), {15'd0, vsync}, {15'd0, eVs});
    checkVal($sformatf("%s.rgb", tag), {13'd0, rgb}, {13'd0, eRgb});
    checkVal($sformatf("%s.frame", tag), frameCnt, frameBase + 16'(edges));
  endtask

  // One pixel: a ticked clock, then an idle clock with scrambled inputs.
  task automatic pixel(input string tag, input logic hs, input logic vs, input logic vo,
                       input logic fix, input logic [2:0] fRgb, input logic [2:0] fOn);
    logic [2:0] r, o;
    r = fix ? fRgb : 3'($urandom_range(7));
    o = fix ? fOn  : 3'($urandom_range(7));
    applyStimulus(1'b1, 1'b1, hs, vs, vo, r, o);
    checkOutput(tag);
    applyStimulus(1'b1, 1'b0, 1'($urandom_range(1)), 1'($urandom_range(1)), 1'($urandom_range(1)),
                  3'($urandom_range(7)), 3'($urandom_range(7)));
    checkOutput(tag);
  endtask

  // One shortened frame; vsync is high on the last line only.
  task automatic runFrame(input string tag, input logic fix, input logic [2:0] fRgb,
                          input logic [2:0] fOn);
    for (int y = 0; y < SV_TOT; y++) begin
      for (int x = 0; x < SH_TOT; x++) begin
        pixel(tag, (x >= SH_S0) && (x < SH_S1), y == SV_SL, (x < SH_VIS) && (y < SV_VIS),
              fix, fRgb, fOn);
      end
    end
  endtask

  // Directed sequence.
  initial begin
    int riseTick, tickAfter;
    logic [2:0] rgbAtRise;
    rstN = 1'b0; pTick = 1'b0; hsIn = 1'b0; vsIn = 1'b0; voIn = 1'b0;
    textRgb = 3'b000; textOn = 3'b000;

    // Reset, including cycles where p_tick is also high.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 1'(i % 2 == 0), 1'b1, 1'b1, 1'b1, RED, 3'b100);
      checkOutput("reset");
    end
    checkVal("reset_frame", frameCnt, 16'h0000);
    checkVal("reset_rgb", {13'd0, rgb}, {13'd0, BLACK});

    // One full-width line: hsync must surface SYNC_DLY ticks after it enters.
    riseTick  = -1;
    tickAfter = 0;
    rgbAtRise = 3'b111;
    for (int x = 0; x < H_TOTAL; x++) begin
      applyStimulus(1'b1, 1'b1, (x >= H_DISPLAY + H_FRONT) && (x < H_DISPLAY + H_FRONT + H_SYNC),
                    1'b0, x < H_DISPLAY, 3'($urandom_range(7)), 3'($urandom_range(7)));
      checkOutput("align");
      if (x >= H_DISPLAY + H_FRONT) begin
        tickAfter++;
        if (hsync === 1'b1 && riseTick < 0) begin
          riseTick  = tickAfter;
          rgbAtRise = rgb;
        end
      end
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'($urandom_range(7)), 3'($urandom_range(7)));
      checkOutput("align");
    end
    checkVal("align_rise", 16'(riseTick), 16'(TB_SYNC_DLY));
    checkVal("align_rgb", {13'd0, rgbAtRise}, {13'd0, BLACK});

    // Blank interval with red text on the input.
    for (int x = 0; x < 40; x++) begin
      pixel("blank", 1'b0, 1'b0, 1'b0, 1'b1, RED, 3'b100);
      checkVal("blank_rgb", {13'd0, rgb}, {13'd0, BLACK});
    end

    // Three frames from reset, then wrap from a preloaded 0xFFFF.
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 3'b000);
    checkOutput("frames");
    for (int f = 0; f < 3; f++) runFrame("frames", 1'b0, BLACK, 3'b000);
    checkVal("frames3", frameCnt, 16'd3);
    @(negedge clk);
    force dut.frame_cnt_q = 16'hFFFF;
    #1;
    release dut.frame_cnt_q;
    frameBase = 16'hFFFF - 16'(edges);
    runFrame("wrap", 1'b0, BLACK, 3'b000);
    checkVal("wrap_frame", frameCnt, 16'h0000);

    // Mid-line reset while vsync is high, then release with vsync still high.
    for (int x = 0; x < 10; x++) pixel("midline", 1'b1, 1'b1, 1'b1, 1'b0, BLACK, 3'b000);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, RED, 3'b100);
    checkOutput("midreset");
    checkVal("midreset_hs", {15'd0, hsync}, 16'd0);
    checkVal("midreset_vs", {15'd0, vsync}, 16'd0);
    checkVal("midreset_rgb", {13'd0, rgb}, 16'd0);
    checkVal("midreset_frame", frameCnt, 16'd0);
    for (int x = 0; x < 10; x++) pixel("release", 1'b0, 1'b1, 1'b1, 1'b0, BLACK, 3'b000);
    checkVal("no_spurious", frameCnt, 16'd0);
    runFrame("restart", 1'b0, BLACK, 3'b000);
    checkVal("restart_frame", frameCnt, 16'd1);

    // Hold: ten clocks without p_tick while everything else changes.
    for (int x = 0; x < 4; x++) pixel("prehold", 1'b0, 1'b0, 1'b1, 1'b0, BLACK, 3'b000);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, 1'b0, 1'($urandom_range(1)), 1'($urandom_range(1)),
                    1'($urandom_range(1)), 3'($urandom_range(7)), 3'($urandom_range(7)));
      checkOutput("hold");
    end

    // Fully random traffic, irregular ticks and the odd reset.
    for (int i = 0; i < 400; i++) begin
      applyStimulus(1'($urandom_range(63) != 0), 1'($urandom_range(1)), 1'($urandom_range(1)),
                    1'($urandom_range(1)), 1'($urandom_range(1)), 3'($urandom_range(7)),
                    3'($urandom_range(7)));
      checkOutput("random");
    end

`ifdef VGA_TEXT_BLINK_EN
    // Blink: red text on region k over six frames.
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 3'b000);
    checkOutput("blink");
    for (int f = 0; f < 6; f++) runFrame("blink", 1'b1, RED, 3'b100);
    checkVal("blink_frames", frameCnt, 16'd6);
`endif

    $display("[TB] %0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
